// File: rtl/counter_pkg.sv
// Shared types for the counter / accumulator SRAM.
// Op encoding matches the raw i_op_a bit.
package counter_pkg;

   typedef enum logic {
      OP_WRITE = 1'b0,
      OP_ACCUM = 1'b1
   } op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/counter_sram_1w2r.sv
// Plain storage array: one write port, two registered read ports.
// No reset on the array so it maps onto block RAM.
module counter_sram_1w2r #(
   parameter int IW    = 12,
   parameter int DW    = 18,
   parameter int DEPTH = 4096
)(
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [IW-1:0] raddr_a,
   output logic [DW-1:0] rdata_a,
   input  logic [IW-1:0] raddr_b,
   output logic [DW-1:0] rdata_b
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
   end

endmodule

// File: rtl/counter_accum_sram.sv
// Dual-port counter memory: pipelined write/accumulate port A,
// bus port B, and a full-array clear sweep.
module counter_accum_sram
   import counter_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 18,
   parameter int DEPTH      = 4096,
   parameter int INC_WIDTH  = 8,
   parameter int SATURATE   = 1
)(
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic                  i_valid_a,
   input  logic                  i_op_a,
   input  logic [ADDR_WIDTH-1:0] i_addr_a,
   input  logic [DATA_WIDTH-1:0] i_data_a,
   input  logic [INC_WIDTH-1:0]  i_inc_a,
   output logic [DATA_WIDTH-1:0] o_data_a,
   input  logic                  i_valid_b,
   input  logic                  i_we_b,
   input  logic [ADDR_WIDTH-1:0] i_addr_b,
   input  logic [DATA_WIDTH-1:0] i_data_b,
   output logic [DATA_WIDTH-1:0] o_data_b,
   output logic                  o_ready_b,
   input  logic                  i_clear,
   output logic                  o_busy,
   output logic                  o_overflow
);

   localparam int AW = ADDR_WIDTH;
   localparam int DW = DATA_WIDTH;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   LIMIT = (AW+1)'(DEPTH);
   localparam logic [IW-1:0] LAST  = IW'(DEPTH-1);

   function automatic logic in_rng(input logic [AW-1:0] a);
      return {1'b0, a} < LIMIT;
   endfunction

   state_e        state;
   logic [IW-1:0] sweep;
   logic          busy, flush;

   logic          s1_valid, s1_rng, s1_byp;
   op_e           s1_op;
   logic [AW-1:0] s1_addr;
   logic [DW-1:0] s1_opnd, s1_byp_data, s1_old;

   logic          s2_valid, s2_rng, s2_carry;
   op_e           s2_op;
   logic [AW-1:0] s2_addr;
   logic [DW-1:0] s2_old, s2_opnd, s2_result;
   logic [DW:0]   s2_sum;

   logic          a_wb, b_acc, b_wr, b_ok, b_byp;
   logic [DW-1:0] b_byp_data, q_a, q_b;
   logic          we;
   logic [IW-1:0] waddr;
   logic [DW-1:0] wdata;

   assign busy  = (state == CLEAR);
   assign flush = busy || i_clear;

   assign s2_sum   = {1'b0, s2_old} + {1'b0, s2_opnd};
   assign s2_carry = (s2_op == OP_ACCUM) && s2_sum[DW];

   always_comb begin
      s2_result = s2_sum[DW-1:0];
      if (s2_op == OP_WRITE)
         s2_result = s2_opnd;
      else if (s2_carry && SATURATE != 0)
         s2_result = '1;
   end

   assign a_wb      = s2_valid && s2_rng && !i_clear;
   assign o_ready_b = !busy && !(i_we_b && a_wb);
   assign b_acc     = i_valid_b && o_ready_b;
   assign b_wr      = b_acc && i_we_b && in_rng(i_addr_b);

   // Newest pending write to the same word wins.
   always_comb begin
      s1_old = q_a;
      if (!s1_rng)
         s1_old = '0;
      else if (s2_valid && s2_addr == s1_addr)
         s1_old = s2_result;
      else if (b_wr && i_addr_b == s1_addr)
         s1_old = i_data_b;
      else if (s1_byp)
         s1_old = s1_byp_data;
   end

   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      unique case (1'b1)
         busy: begin
            we    = 1'b1;
            waddr = sweep;
         end
         a_wb: begin
            we    = 1'b1;
            waddr = s2_addr[IW-1:0];
            wdata = s2_result;
         end
         b_wr: begin
            we    = 1'b1;
            waddr = i_addr_b[IW-1:0];
            wdata = i_data_b;
         end
         default: ;
      endcase
   end

   assign o_data_a = s1_valid ? s1_old : '0;
   assign o_data_b = b_ok ? (b_byp ? b_byp_data : q_b) : '0;
   assign o_busy   = busy;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state <= CLEAR;
         sweep <= '0;
      end else if (i_clear) begin
         state <= CLEAR;
         sweep <= '0;
      end else if (state == CLEAR) begin
         if (sweep == LAST) begin
            state <= IDLE;
            sweep <= '0;
         end else begin
            sweep <= sweep + IW'(1);
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         s1_valid    <= 1'b0;
         s1_op       <= OP_WRITE;
         s1_addr     <= '0;
         s1_rng      <= 1'b0;
         s1_opnd     <= '0;
         s1_byp      <= 1'b0;
         s1_byp_data <= '0;
         s2_valid    <= 1'b0;
         s2_op       <= OP_WRITE;
         s2_addr     <= '0;
         s2_rng      <= 1'b0;
         s2_old      <= '0;
         s2_opnd     <= '0;
         b_ok        <= 1'b0;
         b_byp       <= 1'b0;
         b_byp_data  <= '0;
         o_overflow  <= 1'b0;
      end else begin
         s1_valid    <= i_valid_a && !flush;
         s1_op       <= op_e'(i_op_a);
         s1_addr     <= i_addr_a;
         s1_rng      <= in_rng(i_addr_a);
         s1_opnd     <= i_op_a ? DW'(i_inc_a) : i_data_a;
         s1_byp      <= we && waddr == i_addr_a[IW-1:0];
         s1_byp_data <= wdata;
         s2_valid    <= s1_valid && !flush;
         s2_op       <= s1_op;
         s2_addr     <= s1_addr;
         s2_rng      <= s1_rng;
         s2_old      <= s1_old;
         s2_opnd     <= s1_opnd;
         b_ok        <= b_acc && !i_we_b && in_rng(i_addr_b) && !i_clear;
         b_byp       <= we && waddr == i_addr_b[IW-1:0];
         b_byp_data  <= wdata;
         if (i_clear)
            o_overflow <= 1'b0;
         else if (s2_valid && s2_carry)
            o_overflow <= 1'b1;
      end
   end

   counter_sram_1w2r #(
      .IW    (IW),
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_sram (
      .clk     (i_clk),
      .we      (we),
      .waddr   (waddr),
      .wdata   (wdata),
      .raddr_a (i_addr_a[IW-1:0]),
      .rdata_a (q_a),
      .raddr_b (i_addr_b[IW-1:0]),
      .rdata_b (q_b)
   );

endmodule

// File: tb/tb_counter_accum_sram.sv
// Bench for counter_accum_sram: a saturating and a wrapping instance
// share stimulus; a transaction model feeds expected-value queues.
module tb_counter_accum_sram;

   localparam int AW    = 5;
   localparam int DW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_a, op_a, valid_b, we_b, clear;
   logic [AW-1:0] addr_a, addr_b;
   logic [DW-1:0] data_a, inc_a, data_b;
   logic [DW-1:0] da_s, da_w, db_s, db_w;
   logic          rdy_s, rdy_w, busy_s, busy_w, ovf_s, ovf_w;

   always #5 clk = ~clk;

   counter_accum_sram #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
      .INC_WIDTH(DW), .SATURATE(1)
   ) u_sat (
      .i_clk(clk), .i_rstn(rst_n),
      .i_valid_a(valid_a), .i_op_a(op_a), .i_addr_a(addr_a),
      .i_data_a(data_a), .i_inc_a(inc_a), .o_data_a(da_s),
      .i_valid_b(valid_b), .i_we_b(we_b), .i_addr_b(addr_b),
      .i_data_b(data_b), .o_data_b(db_s), .o_ready_b(rdy_s),
      .i_clear(clear), .o_busy(busy_s), .o_overflow(ovf_s)
   );

   counter_accum_sram #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH),
      .INC_WIDTH(DW), .SATURATE(0)
   ) u_wrap (
      .i_clk(clk), .i_rstn(rst_n),
      .i_valid_a(valid_a), .i_op_a(op_a), .i_addr_a(addr_a),
      .i_data_a(data_a), .i_inc_a(inc_a), .o_data_a(da_w),
      .i_valid_b(valid_b), .i_we_b(we_b), .i_addr_b(addr_b),
      .i_data_b(data_b), .o_data_b(db_w), .o_ready_b(rdy_w),
      .i_clear(clear), .o_busy(busy_w), .o_overflow(ovf_w)
   );

   typedef struct {
      int addr;
      bit op;
      int data;
      int inc;
   } areq_t;

   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] mm [2][DEPTH];
   logic [DW-1:0] qa_s[$], qa_w[$], qb_s[$], qb_w[$];
   bit            ovf_m [2];
   bit            cw [2];
   bit            wb_pend;
   bit            a_pend_v;
   areq_t         a_pend;
   int            busy_left;

   task automatic chk(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic zero_model();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < DEPTH; i++)
            mm[s][i] = '0;
   endtask

   // One clock cycle: drive, check this cycle's outputs, advance model.
   task automatic step(input bit va, input bit opa, input int aa,
                       input int dav, input int ia, input bit vb,
                       input bit web, input int ab, input int dbv,
                       input bit clr);
      bit            busy_e, rdy_e, bacc, nwb;
      bit            cn [2];
      logic [DW-1:0] old, ex;
      logic [DW:0]   sm;
      valid_a = va;
      op_a    = opa;
      addr_a  = AW'(aa);
      data_a  = DW'(dav);
      inc_a   = DW'(ia);
      valid_b = vb;
      we_b    = web;
      addr_b  = AW'(ab);
      data_b  = DW'(dbv);
      clear   = clr;
      #1;
      busy_e = busy_left > 0;
      rdy_e  = !busy_e && !(web && wb_pend);
      chk("busy", DW'(busy_s), DW'(busy_e));
      chk("ready", DW'(rdy_s), DW'(rdy_e));
      chk("ready_wrap", DW'(rdy_w), DW'(rdy_e));
      chk("ovf_sat", DW'(ovf_s), DW'(ovf_m[1]));
      chk("ovf_wrap", DW'(ovf_w), DW'(ovf_m[0]));
      if (qb_s.size() > 0) begin
         chk("rd_b_sat", db_s, qb_s.pop_front());
         chk("rd_b_wrap", db_w, qb_w.pop_front());
      end else if (busy_e) begin
         chk("rd_b_busy", db_s, '0);
      end
      bacc = vb && rdy_e;
      if (bacc && web && ab < DEPTH) begin
         mm[0][ab] = DW'(dbv);
         mm[1][ab] = DW'(dbv);
      end
      if (bacc && !web) begin
         qb_s.push_back(ab < DEPTH ? mm[1][ab] : '0);
         qb_w.push_back(ab < DEPTH ? mm[0][ab] : '0);
      end
      nwb   = 1'b0;
      cn[0] = 1'b0;
      cn[1] = 1'b0;
      if (a_pend_v) begin
         nwb = a_pend.addr < DEPTH;
         for (int s = 0; s < 2; s++) begin
            old = '0;
            if (nwb) old = mm[s][a_pend.addr];
            if (a_pend.op) begin
               sm    = {1'b0, old} + {1'b0, DW'(a_pend.inc)};
               cn[s] = sm[DW];
               ex    = (sm[DW] && s == 1) ? '1 : sm[DW-1:0];
            end else begin
               ex = DW'(a_pend.data);
            end
            if (nwb) mm[s][a_pend.addr] = ex;
            if (s == 1) qa_s.push_back(old);
            else        qa_w.push_back(old);
         end
      end
      if (qa_s.size() > 0) begin
         chk("rd_a_sat", da_s, qa_s.pop_front());
         chk("rd_a_wrap", da_w, qa_w.pop_front());
      end else if (busy_e) begin
         chk("rd_a_busy", da_s, '0);
      end
      for (int s = 0; s < 2; s++) begin
         if (clr)        ovf_m[s] = 1'b0;
         else if (cw[s]) ovf_m[s] = 1'b1;
         cw[s] = clr ? 1'b0 : cn[s];
      end
      wb_pend = nwb && !clr;
      if (clr) begin
         zero_model();
         busy_left = DEPTH;
      end else if (busy_left > 0) begin
         busy_left--;
      end
      a_pend_v = va && !busy_e && !clr;
      a_pend   = '{addr: aa, op: opa, data: dav, inc: ia};
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic rd_b(input int a);
      step(0, 0, 0, 0, 0, 1, 0, a, 0, 0);
   endtask

   task automatic wr_b(input int a, input int d);
      step(0, 0, 0, 0, 0, 1, 1, a, d, 0);
   endtask

   task automatic acc_a(input int a, input int inc);
      step(1, 1, a, 0, inc, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n   = 1'b0;
      valid_a = 1'b0;
      op_a    = 1'b0;
      addr_a  = '0;
      data_a  = '0;
      inc_a   = '0;
      valid_b = 1'b0;
      we_b    = 1'b0;
      addr_b  = '0;
      data_b  = '0;
      clear   = 1'b0;
      zero_model();
      wb_pend   = 1'b0;
      a_pend_v  = 1'b0;
      busy_left = DEPTH;
      for (int s = 0; s < 2; s++) begin
         ovf_m[s] = 1'b0;
         cw[s]    = 1'b0;
      end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_data_a", da_s, '0);
      chk("rst_data_b", db_s, '0);
      chk("rst_ovf", DW'(ovf_s), '0);
      rst_n = 1'b1;

      // power-up sweep, then every word reads back zero
      idle(DEPTH);
      for (int i = 0; i < DEPTH; i++) rd_b(i);
      idle(1);

      // ten back-to-back +1 accumulates on one word
      for (int i = 0; i < 10; i++) acc_a(5, 1);
      idle(2);
      rd_b(5);
      idle(1);

      // 15 + 3: clamp vs wrap, both flag overflow
      wr_b(7, 15);
      acc_a(7, 3);
      idle(2);
      rd_b(7);
      idle(2);

      // bus write lands while the accumulate sits in S1
      acc_a(9, 2);
      wr_b(9, 6);
      idle(2);
      rd_b(9);
      idle(1);

      // bus write collides with write-back, held one cycle
      acc_a(3, 1);
      idle(1);
      wr_b(3, 12);
      wr_b(3, 12);
      idle(1);
      rd_b(3);
      idle(1);

      // out-of-range address from both ports
      step(1, 0, DEPTH, 9, 0, 1, 1, DEPTH, 5, 0);
      idle(1);
      acc_a(DEPTH, 2);
      idle(2);
      rd_b(DEPTH);
      rd_b(0);
      idle(1);

      // mixed random traffic
      for (int k = 0; k < 80; k++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, DEPTH + 1)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, DEPTH + 1)),
              int'($urandom_range(0, 15)), 1'b0);
      end
      idle(3);
      for (int i = 0; i < 4; i++) rd_b(i);
      idle(1);

      // clear while accumulates keep arriving
      acc_a(1, 5);
      acc_a(2, 5);
      step(1, 1, 1, 0, 5, 0, 0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) acc_a(1, 5);
      for (int i = 0; i < DEPTH; i++) rd_b(i);
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
